// File: rtl/rat_int_ctrl.sv
// rat_int_ctrl: edge-latched, maskable, round-robin interrupt controller for the RAT MCU
module rat_int_ctrl #(
  parameter int N_SRC = 4,
  parameter int ID_W  = 2
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [N_SRC-1:0] IRQ,
  input  logic             MASK_WR,
  input  logic [N_SRC-1:0] MASK_DATA,
  input  logic             INT_ACK,
  input  logic             INT_DONE,
  output logic             INT_CU,
  output logic [ID_W-1:0]  INT_ID,
  output logic [N_SRC-1:0] PENDING,
  output logic             IN_SERVICE
);
  typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;
  state_t state, state_n;
  logic [N_SRC-1:0] irq_q, mask, rise, eligible, clr;
  logic [ID_W-1:0] rr_ptr, rr_n, id_n, winner;
  logic found;

  function automatic logic [ID_W-1:0] wrap(input int v);
    return ID_W'(v >= N_SRC ? v - N_SRC : v);
  endfunction

  assign rise = IRQ & ~irq_q;
  assign eligible = PENDING & mask;

  // first eligible source scanning upward from rr_ptr with wrap
  always_comb begin
    winner = '0;
    found = 1'b0;
    for (int k = 0; k < N_SRC; k++) begin
      if (!found && eligible[wrap(int'(rr_ptr) + k)]) begin
        found = 1'b1;
        winner = wrap(int'(rr_ptr) + k);
      end
    end
  end

  // next state, held ID, round-robin pointer and pending-clear decode
  always_comb begin
    state_n = state;
    id_n = INT_ID;
    rr_n = rr_ptr;
    clr = '0;
    case (state)
      IDLE: if (found) begin
        id_n = winner;
        state_n = REQ;
      end
      REQ: if (INT_ACK) begin
        clr[INT_ID] = 1'b1;
        rr_n = wrap(int'(INT_ID) + 1);
        state_n = SERVICE;
      end
      SERVICE: state_n = INT_DONE ? IDLE : SERVICE;
      default: state_n = IDLE;
    endcase
  end

  // registers; irq_q tracks IRQ even in reset so a held line makes no edge
  always_ff @(posedge CLK) begin
    irq_q <= IRQ;
    if (!RESET) begin
      state <= IDLE;
      INT_CU <= 1'b0;
      INT_ID <= '0;
      PENDING <= '0;
      IN_SERVICE <= 1'b0;
      mask <= '0;
      rr_ptr <= '0;
    end else begin
      state <= state_n;
      INT_CU <= state_n == REQ;
      IN_SERVICE <= state_n == SERVICE;
      INT_ID <= id_n;
      PENDING <= (PENDING & ~clr) | rise;
      mask <= MASK_WR ? MASK_DATA : mask;
      rr_ptr <= rr_n;
    end
  end
endmodule

// File: tb/tb_rat_int_ctrl.sv
// tb_rat_int_ctrl: directed scenario tests for rat_int_ctrl
module tb_rat_int_ctrl;
  logic CLK = 1'b0;
  logic RESET;
  logic [3:0] IRQ;
  logic MASK_WR;
  logic [3:0] MASK_DATA;
  logic INT_ACK;
  logic INT_DONE;
  logic INT_CU;
  logic [1:0] INT_ID;
  logic [3:0] PENDING;
  logic IN_SERVICE;
  int checks = 0;
  int errors = 0;

  rat_int_ctrl #(.N_SRC(4), .ID_W(2)) dut (
    .CLK(CLK), .RESET(RESET), .IRQ(IRQ), .MASK_WR(MASK_WR), .MASK_DATA(MASK_DATA),
    .INT_ACK(INT_ACK), .INT_DONE(INT_DONE), .INT_CU(INT_CU), .INT_ID(INT_ID),
    .PENDING(PENDING), .IN_SERVICE(IN_SERVICE)
  );

  always #5 CLK = ~CLK;

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic write_mask(input logic [3:0] m);
    MASK_WR = 1'b1;
    MASK_DATA = m;
    tick();
    MASK_WR = 1'b0;
  endtask

  task automatic pulse_irq(input logic [3:0] v);
    IRQ = v;
    tick();
    IRQ = 4'b0000;
  endtask

  task automatic serve();
    INT_ACK = 1'b1;
    tick();
    INT_ACK = 1'b0;
    INT_DONE = 1'b1;
    tick();
    INT_DONE = 1'b0;
  endtask

  task automatic do_reset();
    RESET = 1'b0;
    tick();
    RESET = 1'b1;
  endtask

  task automatic test_reset();
    RESET = 1'b0;
    IRQ = 4'b0001;
    tick(2);
    RESET = 1'b1;
    write_mask(4'b1111);
    checks++; if (INT_ID !== 2'd0) begin errors++; $display("FAIL reset_id: got %0d want 0", INT_ID); end
    checks++; if (IN_SERVICE !== 1'b0) begin errors++; $display("FAIL reset_insvc: got %b want 0", IN_SERVICE); end
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++; if (PENDING !== 4'b0000) begin errors++; $display("FAIL reset_no_edge_pend: got %b want 0000", PENDING); end
      checks++; if (INT_CU !== 1'b0) begin errors++; $display("FAIL reset_no_edge_cu: got %b want 0", INT_CU); end
    end
    IRQ = 4'b0000;
    tick();
    pulse_irq(4'b0100);
    tick();
    checks++; if (INT_CU !== 1'b1) begin errors++; $display("FAIL reset_pre_req: got %b want 1", INT_CU); end
    do_reset();
    checks++; if (INT_CU !== 1'b0) begin errors++; $display("FAIL reset_abort_cu: got %b want 0", INT_CU); end
    checks++; if (PENDING !== 4'b0000) begin errors++; $display("FAIL reset_abort_pend: got %b want 0000", PENDING); end
  endtask

  task automatic test_basic();
    write_mask(4'b1111);
    pulse_irq(4'b0100);
    checks++; if (PENDING !== 4'b0100) begin errors++; $display("FAIL basic_pend: got %b want 0100", PENDING); end
    checks++; if (INT_CU !== 1'b0) begin errors++; $display("FAIL basic_cu_early: got %b want 0", INT_CU); end
    tick();
    checks++; if (INT_CU !== 1'b1) begin errors++; $display("FAIL basic_cu: got %b want 1", INT_CU); end
    checks++; if (INT_ID !== 2'd2) begin errors++; $display("FAIL basic_id: got %0d want 2", INT_ID); end
    INT_ACK = 1'b1;
    tick();
    INT_ACK = 1'b0;
    checks++; if (PENDING !== 4'b0000) begin errors++; $display("FAIL basic_ack_pend: got %b want 0000", PENDING); end
    checks++; if (INT_CU !== 1'b0) begin errors++; $display("FAIL basic_ack_cu: got %b want 0", INT_CU); end
    checks++; if (IN_SERVICE !== 1'b1) begin errors++; $display("FAIL basic_insvc: got %b want 1", IN_SERVICE); end
    checks++; if (INT_ID !== 2'd2) begin errors++; $display("FAIL basic_id_hold: got %0d want 2", INT_ID); end
    INT_DONE = 1'b1;
    tick();
    INT_DONE = 1'b0;
    checks++; if (IN_SERVICE !== 1'b0) begin errors++; $display("FAIL basic_done: got %b want 0", IN_SERVICE); end
    tick();
    checks++; if (INT_CU !== 1'b0) begin errors++; $display("FAIL basic_idle_cu: got %b want 0", INT_CU); end
  endtask

  task automatic test_simultaneous();
    do_reset();
    write_mask(4'b1111);
    pulse_irq(4'b1010);
    checks++; if (PENDING !== 4'b1010) begin errors++; $display("FAIL simul_pend: got %b want 1010", PENDING); end
    tick();
    checks++; if (INT_ID !== 2'd1 || INT_CU !== 1'b1) begin errors++; $display("FAIL simul_first: got id %0d cu %b want id 1 cu 1", INT_ID, INT_CU); end
    INT_ACK = 1'b1;
    tick();
    INT_ACK = 1'b0;
    checks++; if (PENDING !== 4'b1000) begin errors++; $display("FAIL simul_ack_pend: got %b want 1000", PENDING); end
    INT_DONE = 1'b1;
    tick();
    INT_DONE = 1'b0;
    checks++; if (INT_CU !== 1'b0 || IN_SERVICE !== 1'b0) begin errors++; $display("FAIL simul_done: got cu %b insvc %b want 0 0", INT_CU, IN_SERVICE); end
    tick();
    checks++; if (INT_ID !== 2'd3 || INT_CU !== 1'b1) begin errors++; $display("FAIL simul_second: got id %0d cu %b want id 3 cu 1", INT_ID, INT_CU); end
    serve();
    checks++; if (PENDING !== 4'b0000) begin errors++; $display("FAIL simul_drain: got %b want 0000", PENDING); end
  endtask

  task automatic test_round_robin();
    pulse_irq(4'b1010);
    tick();
    checks++; if (INT_ID !== 2'd1) begin errors++; $display("FAIL rr_wrap_to_0: got %0d want 1", INT_ID); end
    serve();
    pulse_irq(4'b1001);
    tick();
    checks++; if (INT_ID !== 2'd3) begin errors++; $display("FAIL rr_first: got %0d want 3", INT_ID); end
    serve();
    tick();
    checks++; if (INT_ID !== 2'd0 || INT_CU !== 1'b1) begin errors++; $display("FAIL rr_second: got id %0d cu %b want id 0 cu 1", INT_ID, INT_CU); end
    serve();
  endtask

  task automatic test_mask();
    write_mask(4'b0000);
    pulse_irq(4'b0001);
    checks++; if (PENDING !== 4'b0001) begin errors++; $display("FAIL mask_pend: got %b want 0001", PENDING); end
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++; if (INT_CU !== 1'b0) begin errors++; $display("FAIL mask_blocked: got %b want 0", INT_CU); end
    end
    INT_ACK = 1'b1;
    tick();
    INT_ACK = 1'b0;
    checks++; if (PENDING !== 4'b0001) begin errors++; $display("FAIL mask_ack_idle: got %b want 0001", PENDING); end
    write_mask(4'b0001);
    checks++; if (INT_CU !== 1'b0) begin errors++; $display("FAIL mask_edge_m: got %b want 0", INT_CU); end
    tick();
    checks++; if (INT_CU !== 1'b1 || INT_ID !== 2'd0) begin errors++; $display("FAIL mask_enable: got cu %b id %0d want cu 1 id 0", INT_CU, INT_ID); end
    write_mask(4'b0000);
    tick();
    checks++; if (INT_CU !== 1'b1) begin errors++; $display("FAIL mask_no_withdraw: got %b want 1", INT_CU); end
    serve();
  endtask

  task automatic test_no_nest();
    write_mask(4'b1111);
    pulse_irq(4'b0100);
    tick();
    INT_ACK = 1'b1;
    tick();
    INT_ACK = 1'b0;
    pulse_irq(4'b0010);
    checks++; if (PENDING !== 4'b0010) begin errors++; $display("FAIL nest_pend: got %b want 0010", PENDING); end
    tick(3);
    checks++; if (INT_CU !== 1'b0 || IN_SERVICE !== 1'b1) begin errors++; $display("FAIL nest_hold: got cu %b insvc %b want 0 1", INT_CU, IN_SERVICE); end
    INT_DONE = 1'b1;
    tick();
    INT_DONE = 1'b0;
    checks++; if (INT_CU !== 1'b0) begin errors++; $display("FAIL nest_done_edge: got %b want 0", INT_CU); end
    tick();
    checks++; if (INT_CU !== 1'b1 || INT_ID !== 2'd1) begin errors++; $display("FAIL nest_next: got cu %b id %0d want cu 1 id 1", INT_CU, INT_ID); end
    IRQ = 4'b0010;
    INT_ACK = 1'b1;
    tick();
    IRQ = 4'b0000;
    INT_ACK = 1'b0;
    checks++; if (PENDING !== 4'b0010) begin errors++; $display("FAIL set_wins: got %b want 0010", PENDING); end
    checks++; if (IN_SERVICE !== 1'b1) begin errors++; $display("FAIL set_wins_svc: got %b want 1", IN_SERVICE); end
    INT_DONE = 1'b1;
    tick();
    INT_DONE = 1'b0;
    tick();
    checks++; if (INT_CU !== 1'b1 || INT_ID !== 2'd1) begin errors++; $display("FAIL set_wins_again: got cu %b id %0d want cu 1 id 1", INT_CU, INT_ID); end
    INT_ACK = 1'b1;
    INT_DONE = 1'b1;
    tick();
    INT_ACK = 1'b0;
    INT_DONE = 1'b0;
    checks++; if (IN_SERVICE !== 1'b1) begin errors++; $display("FAIL ack_done_same: got %b want 1", IN_SERVICE); end
    INT_DONE = 1'b1;
    tick();
    INT_DONE = 1'b0;
    checks++; if (IN_SERVICE !== 1'b0 || INT_CU !== 1'b0) begin errors++; $display("FAIL final_idle: got insvc %b cu %b want 0 0", IN_SERVICE, INT_CU); end
  endtask

  initial begin
    RESET = 1'b0;
    IRQ = 4'b0000;
    MASK_WR = 1'b0;
    MASK_DATA = 4'b0000;
    INT_ACK = 1'b0;
    INT_DONE = 1'b0;
    test_reset();
    test_basic();
    test_simultaneous();
    test_round_robin();
    test_mask();
    test_no_nest();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
